// File: rtl/load_store_unit_if.sv
// Word-organised data-memory port: the load/store unit is the master, the data memory the slave.
interface load_store_unit_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    logic              dmem_req;
    logic              dmem_we;
    logic [BE_W-1:0]   dmem_be;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ready;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_be,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_be,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit for the multicycle core: lane steering, load extension,
// alignment checks and a bus-timeout watchdog in front of a word-wide data memory.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_mem_read,
    input  logic        ctrl_mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stat_mem_read_done,
    output logic        stat_mem_write_done,
    output logic        stat_mem_fault,
    load_store_unit_if.master mem
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        DONE,
        FAULT,
        RELEASE
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] addr_q, addr_next;
    logic [2:0]        f3_q, f3_next;
    logic [DATA_W-1:0] wdata_q, wdata_next;
    logic              store_q, store_next;
    logic [CNT_W-1:0]  cnt_q, cnt_next;

    logic [DATA_W-1:0] read_data_next;
    logic              read_done_next, write_done_next, fault_next;
    logic              req_next, we_next;
    logic [BE_W-1:0]   be_next;
    logic [ADDR_W-1:0] maddr_next;
    logic [DATA_W-1:0] mwdata_next;

    // Funct3 legality plus natural alignment of the byte offset.
    function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                       input logic [1:0] ofs);
        logic ok;
        unique case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = !ofs[0];
            F3_W:    ok = (ofs == 2'b00);
            F3_BU:   ok = !is_store;
            F3_HU:   ok = !is_store && !ofs[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [BE_W-1:0] lane_be(input logic [2:0] f3, input logic [1:0] ofs);
        logic [BE_W-1:0] be;
        unique case (f3[1:0])
            2'b00:   be = BE_W'(4'b0001 << ofs);
            2'b01:   be = ofs[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [DATA_W-1:0] lane_data(input logic [2:0] f3,
                                                    input logic [DATA_W-1:0] data);
        logic [DATA_W-1:0] d;
        unique case (f3[1:0])
            2'b00:   d = {4{data[7:0]}};
            2'b01:   d = {2{data[15:0]}};
            default: d = data;
        endcase
        return d;
    endfunction

    // Pick the addressed byte/halfword lane and extend it to a full word.
    function automatic logic [DATA_W-1:0] extend_load(input logic [2:0] f3, input logic [1:0] ofs,
                                                      input logic [DATA_W-1:0] word);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = 8'(word >> {ofs, 3'b000});
        h = ofs[1] ? word[31:16] : word[15:0];
        unique case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_BU:   r = {24'd0, b};
            F3_HU:   r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        addr_next       = addr_q;
        f3_next         = f3_q;
        wdata_next      = wdata_q;
        store_next      = store_q;
        cnt_next        = cnt_q;
        read_data_next  = read_data;
        req_next        = 1'b0;
        we_next         = 1'b0;
        be_next         = '0;
        maddr_next      = '0;
        mwdata_next     = '0;
        read_done_next  = 1'b0;
        write_done_next = 1'b0;
        fault_next      = 1'b0;

        unique case (state)
            IDLE: begin
                if (ctrl_mem_read || ctrl_mem_write) begin
                    addr_next  = address;
                    f3_next    = funct3;
                    wdata_next = write_data;
                    store_next = ctrl_mem_write;
                    if ((ctrl_mem_read && ctrl_mem_write) ||
                        !access_ok(ctrl_mem_write, funct3, address[1:0])) begin
                        state_next = FAULT;
                    end else begin
                        state_next = REQ;
                        cnt_next   = '0;
                    end
                end
            end
            REQ: begin
                if (mem.dmem_ready) begin
                    state_next = DONE;
                    if (!store_q) begin
                        read_data_next = extend_load(f3_q, addr_q[1:0], mem.dmem_rdata);
                    end
                end else if (cnt_q == TIMEOUT_LIMIT) begin
                    state_next = FAULT;
                end else begin
                    cnt_next = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_next = RELEASE;
            FAULT:   state_next = RELEASE;
            RELEASE: begin
                // Wait for the core to drop its registered control so it cannot re-trigger.
                if (!ctrl_mem_read && !ctrl_mem_write) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Bus outputs are registered from the next state so they stay stable across REQ.
        if (state_next == REQ) begin
            req_next    = 1'b1;
            we_next     = store_next;
            be_next     = lane_be(f3_next, addr_next[1:0]);
            maddr_next  = {addr_next[ADDR_W-1:2], 2'b00};
            mwdata_next = lane_data(f3_next, wdata_next);
        end
        read_done_next  = (state_next == DONE) && !store_next;
        write_done_next = (state_next == DONE) && store_next;
        fault_next      = (state_next == FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q              <= '0;
            f3_q                <= '0;
            wdata_q             <= '0;
            store_q             <= 1'b0;
            cnt_q               <= '0;
            read_data           <= '0;
            stat_mem_read_done  <= 1'b0;
            stat_mem_write_done <= 1'b0;
            stat_mem_fault      <= 1'b0;
            mem.dmem_req        <= 1'b0;
            mem.dmem_we         <= 1'b0;
            mem.dmem_be         <= '0;
            mem.dmem_addr       <= '0;
            mem.dmem_wdata      <= '0;
        end else begin
            addr_q              <= addr_next;
            f3_q                <= f3_next;
            wdata_q             <= wdata_next;
            store_q             <= store_next;
            cnt_q               <= cnt_next;
            read_data           <= read_data_next;
            stat_mem_read_done  <= read_done_next;
            stat_mem_write_done <= write_done_next;
            stat_mem_fault      <= fault_next;
            mem.dmem_req        <= req_next;
            mem.dmem_we         <= we_next;
            mem.dmem_be         <= be_next;
            mem.dmem_addr       <= maddr_next;
            mem.dmem_wdata      <= mwdata_next;
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory load/store unit for the multicycle RISC-V core. It sits directly downstream of the ALU and takes the ALU result as the effective address. It serves the core FSM's READ_MEMORY and WRITE_MEMORY states through the ctrl_/stat_ handshake, and drives a word-organised data memory through a req/ready port. The unit handles:
- byte-lane steering for stores;
- sign/zero extension for loads;
- alignment checking;
- a bus-timeout watchdog.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 15: number of consecutive cycles with dmem_req high and dmem_ready low before a fault is raised (1..255).

Ports:
- clk  input  1  clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- ctrl_mem_read  input  1  load request (level), sampled in IDLE
- ctrl_mem_write  input  1  store request (level), sampled in IDLE
- funct3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
- address  input  32  effective byte address (ALU result)
- write_data  input  32  store data (rs2 value)
- read_data  output  32  extended load result; holds until the next successful load
- stat_mem_read_done  output  1  one-cycle pulse when a load completes
- stat_mem_write_done  output  1  one-cycle pulse when a store completes
- stat_mem_fault  output  1  one-cycle pulse on a misaligned access, illegal funct3, both requests at once, or timeout
- dmem_req  output  1  memory request
- dmem_we  output  1  1 = write
- dmem_be  output  4  byte enables; bit i selects byte lane i
- dmem_addr  output  32  word address, {address[31:2],2'b00}
- dmem_wdata  output  32  lane-replicated store data
- dmem_ready  input  1  memory accepts/completes the request this cycle
- dmem_rdata  input  32  read word; valid in the cycle dmem_ready=1 for a read

## Operation
- States: IDLE, REQ, DONE, FAULT, RELEASE.
- IDLE: when exactly one of ctrl_mem_read / ctrl_mem_write is high, latch address, funct3 and write_data, then check the access:
  - Legal loads are funct3 000/001/010/100/101. Legal stores are 000/001/010.
  - H/HU accesses need address[0]=0. W accesses need address[1:0]=0.
  - If both requests are high, or the access is illegal or misaligned, go to FAULT. No memory request is issued.
  - Otherwise go to REQ.
- REQ: dmem_req=1. dmem_we=1 for a store. dmem_addr, dmem_be and dmem_wdata stay constant for the whole state.
  - When dmem_ready=1: go to DONE. For a load, capture the extended data into read_data.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYCLES, go to FAULT.
- DONE: pulse stat_mem_read_done or stat_mem_write_done (only one), then go to RELEASE.
- FAULT: pulse stat_mem_fault, then go to RELEASE. read_data is unchanged.
- RELEASE: wait until ctrl_mem_read=0 and ctrl_mem_write=0, then go to IDLE. This prevents re-triggering, because the core deasserts its registered control one cycle after seeing the status.
- Byte enables and write data:
  - B/BU: dmem_be = 4'b0001 << address[1:0]; dmem_wdata = {4{write_data[7:0]}}.
  - H/HU: dmem_be = address[1] ? 4'b1100 : 4'b0011; dmem_wdata = {2{write_data[15:0]}}.
  - W: dmem_be = 4'b1111; dmem_wdata = write_data.
  - Loads drive the same dmem_be pattern with dmem_we=0.
- Load extension: select the byte or halfword lane given by address[1:0].
  - B and H are sign-extended to 32 bits.
  - BU and HU are zero-extended.
  - W is passed through unchanged.
- The timeout counter clears on entry to REQ. It is 8 bits wide.

## Timing
- Reset, when sampled high at a clock edge, returns everything to its reset value:
  - state = IDLE;
  - all dmem_* outputs = 0;
  - all stat_* outputs = 0;
  - read_data = 0;
  - timeout counter = 0.
- Reset in the middle of REQ drops dmem_req at that edge. No status pulse is produced.
- All outputs are registered.
- Minimum latency: the request is sampled at edge 0, dmem_req is high in cycle 1, dmem_ready=1 in cycle 1, and the done pulse is high in cycle 2. The data and address checks therefore take 2 cycles from request to done.
- Fault detected in IDLE: stat_mem_fault is high in cycle 1.
- Timeout: the fault pulse occurs TIMEOUT_CYCLES+1 cycles after dmem_req rises, and dmem_req falls in the same cycle as the fault pulse.
- read_data updates in the same cycle that stat_mem_read_done rises.
- Requests presented while the unit is in REQ, DONE, FAULT or RELEASE are ignored.

## Test plan
- LB/LBU at address 0x103 with dmem_rdata=0x80FF1234, ready immediate: dmem_be=1000; read_data=0xFFFFFF80 for LB, 0x00000080 for LBU. Done pulse one cycle, 2 cycles after the request.
- SH at address 0x202 with write_data=0xAAAA5678: dmem_addr=0x200, dmem_be=1100, dmem_wdata=0x56785678, dmem_we=1. stat_mem_write_done pulses once.
- LW at address 0x201: no dmem_req; stat_mem_fault pulses in cycle 1; read_data keeps its previous value.
- Load with dmem_ready held low, TIMEOUT_CYCLES=15: dmem_req high for 16 cycles, then stat_mem_fault pulses; no done pulse.
- ctrl_mem_read held high for 3 cycles after the done pulse: exactly one access and one pulse. Next access is accepted only after the control goes low and high again.
- Reset asserted during REQ with ready low: dmem_req=0 and all stat_* outputs=0 at the next edge; a following LW at 0x0 completes normally.
